// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe : RISC-V decode stage with its own ID/EX pipeline register.
//
// Contents: register file (x0 reads as zero), control decoder, I/S/B
// immediate generator, load-use hazard detection, ID/EX register.
//
// Parameters:
//   XLEN     datapath width (32 or 64); immediates sign-extend to XLEN
//   NREG     architectural register count (32 = RV32I, 16 = RV32E)
//   RF_RESET 1 = register file cleared on reset, 0 = not reset
//
// Optional build macro:
//   ID_WB_BYPASS_EN  when defined, a same-cycle writeback to rs1/rs2 is
//                    captured into ID/EX instead of the stale array value.
//
// Ports:
//   clk, reset (async, active-low)
//   IF/ID side : id_valid, instr, pc, pc_plus4, stall (out, combinational)
//   WB side    : wb_reg_write, wb_rd, wb_data
//   EX side    : ex_mem_read, ex_rd, flush
//   ID/EX out  : ex_valid, ex_pc, ex_pc_plus4, rs1_data, rs2_data, imm,
//                ex_rs1, ex_rs2, rd, funct3, funct7, reg_write, mem_read,
//                mem_write, mem_to_reg, alu_src, branch, alu_op, illegal
//
// Flow control: id_valid marks a real instruction in IF/ID. The stage
// consumes it on a clk edge only when stall=0 and flush=0; stall=1 means
// IF must hold PC and IF/ID unchanged. Every edge that does not consume an
// instruction loads a bubble (ex_valid=0, all fields 0) into ID/EX. flush
// kills the instruction in ID and wins over stall.
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RF_RESET = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            alu_src,
  output logic            branch,
  output logic [1:0]      alu_op,
  output logic            illegal
);

  localparam int          IDXW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0]  NREG_L = 6'(NREG);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // ---------------------------------------------------------------- fields
  logic [6:0] w_op;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_op  = instr[6:0];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];
  assign w_rd  = instr[11:7];

  // --------------------------------------------------------------- decoder
  logic            w_legal_op;
  logic            w_rs2_used;
  logic            w_rd_used;
  logic            w_idx_bad;
  logic            w_illegal;
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_mem_to_reg;
  logic            w_alu_src;
  logic            w_branch;
  logic [1:0]      w_alu_op;
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_legal_op   = 1'b0;
    w_rs2_used   = 1'b0;
    w_rd_used    = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    w_imm        = '0;
    case (w_op)
      OP_R: begin
        w_legal_op  = 1'b1;
        w_rs2_used  = 1'b1;
        w_rd_used   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_I: begin
        w_legal_op  = 1'b1;
        w_rd_used   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b11;
        w_imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_LD: begin
        w_legal_op   = 1'b1;
        w_rd_used    = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_imm        = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_ST: begin
        w_legal_op  = 1'b1;
        w_rs2_used  = 1'b1;
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BR: begin
        w_legal_op = 1'b1;
        w_rs2_used = 1'b1;
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
        w_imm      = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      end
      default: ;
    endcase

    // Only indices the format actually names can make the instruction
    // illegal; an S/B "rd" field is immediate bits, not a register.
    w_idx_bad = ({1'b0, w_rs1} >= NREG_L) |
                (w_rs2_used & ({1'b0, w_rs2} >= NREG_L)) |
                (w_rd_used  & ({1'b0, w_rd}  >= NREG_L));
    w_illegal = ~w_legal_op | w_idx_bad;

    if (w_illegal) begin
      w_reg_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_alu_src    = 1'b0;
      w_branch     = 1'b0;
      w_alu_op     = 2'b00;
    end
  end

  // -------------------------------------------------------- hazard / flow
  // rs1 is read by every legal opcode, so legality doubles as "rs1 used".
  logic w_stall;
  logic w_advance;

  assign w_stall = id_valid & ~flush & ex_mem_read & (ex_rd != 5'd0) &
                   (((ex_rd == w_rs1) & w_legal_op) |
                    ((ex_rd == w_rs2) & w_rs2_used));
  assign w_advance = id_valid & ~flush & ~w_stall;
  assign stall     = w_stall;

  // --------------------------------------------------------- register file
  logic [XLEN-1:0] r_rf [NREG];
  logic            w_wb_en;

  assign w_wb_en = wb_reg_write & (wb_rd != 5'd0) & ({1'b0, wb_rd} < NREG_L);

  generate
    if (RF_RESET != 0) begin : g_rf_rst
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_wb_en) begin
          r_rf[wb_rd[IDXW-1:0]] <= wb_data;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (w_wb_en) r_rf[wb_rd[IDXW-1:0]] <= wb_data;
      end
    end
  endgenerate

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  always_comb begin
    // x0 and out-of-range indices never touch the array.
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != 5'd0 && {1'b0, w_rs1} < NREG_L) w_rs1_val = r_rf[w_rs1[IDXW-1:0]];
    if (w_rs2 != 5'd0 && {1'b0, w_rs2} < NREG_L) w_rs2_val = r_rf[w_rs2[IDXW-1:0]];
`ifdef ID_WB_BYPASS_EN
    // Write-before-read: a writeback landing this edge is what EX must see.
    if (w_wb_en && wb_rd == w_rs1) w_rs1_val = wb_data;
    if (w_wb_en && wb_rd == w_rs2) w_rs2_val = wb_data;
`endif
  end

  // ------------------------------------------------------- ID/EX register
  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_pc_plus4;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_ex_rs1;
  logic [4:0]      r_ex_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic            r_funct7;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_mem_to_reg;
  logic            r_alu_src;
  logic            r_branch;
  logic [1:0]      r_alu_op;
  logic            r_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !w_advance) begin
      // Reset and bubble load the same all-zero word.
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_pc_plus4 <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_rd          <= '0;
      r_funct3      <= '0;
      r_funct7      <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src     <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_op      <= 2'b00;
      r_illegal     <= 1'b0;
    end else begin
      r_ex_valid    <= 1'b1;
      r_ex_pc       <= pc;
      r_ex_pc_plus4 <= pc_plus4;
      r_rs1_data    <= w_rs1_val;
      r_rs2_data    <= w_rs2_val;
      r_imm         <= w_imm;
      r_ex_rs1      <= w_rs1;
      r_ex_rs2      <= w_rs2;
      r_rd          <= w_rd;
      r_funct3      <= instr[14:12];
      r_funct7      <= instr[30];
      r_reg_write   <= w_reg_write;
      r_mem_read    <= w_mem_read;
      r_mem_write   <= w_mem_write;
      r_mem_to_reg  <= w_mem_to_reg;
      r_alu_src     <= w_alu_src;
      r_branch      <= w_branch;
      r_alu_op      <= w_alu_op;
      r_illegal     <= w_illegal;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_pc_plus4 = r_ex_pc_plus4;
  assign rs1_data    = r_rs1_data;
  assign rs2_data    = r_rs2_data;
  assign imm         = r_imm;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign rd          = r_rd;
  assign funct3      = r_funct3;
  assign funct7      = r_funct7;
  assign reg_write   = r_reg_write;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_to_reg  = r_mem_to_reg;
  assign alu_src     = r_alu_src;
  assign branch      = r_branch;
  assign alu_op      = r_alu_op;
  assign illegal     = r_illegal;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the pipelined RISC-V core, between the IF/ID register and EX.
- Contains the register file (x0 hardwired to zero), the control decoder, the immediate generator, load-use hazard detection and its own ID/EX pipeline register.
- Exports stall/bubble control to IF and accepts a flush from EX on a taken branch.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64). Immediates are sign-extended to XLEN.
- NREG, 32, architectural register count (32 = RV32I, 16 = RV32E). Register index width is log2(NREG).
- RF_RESET, 1, 1 = all registers cleared on reset; 0 = registers not reset.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- instr  in  32  instruction from IF/ID.
- pc  in  XLEN  PC of instr.
- pc_plus4  in  XLEN  pc+4 from IF.
- wb_reg_write  in  1  writeback enable.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination of the instruction in EX.
- flush  in  1  taken branch resolved in EX; kill the instruction in ID.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX valid.
- ex_pc, ex_pc_plus4  out  XLEN each  registered PC values.
- rs1_data, rs2_data  out  XLEN each  registered operands.
- imm  out  XLEN  registered immediate.
- ex_rs1, ex_rs2, rd  out  5 each  registered register indices (ex_rs1/ex_rs2 feed the EX forwarding unit).
- funct3  out  3  registered instr[14:12].
- funct7  out  1  registered instr[30].
- reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch  out  1 each  registered control signals.
- alu_op  out  2  registered ALU op class.
- illegal  out  1  registered; unknown opcode with id_valid set.

Behaviour:
- Reset (reset=0, asynchronous): every ID/EX output is 0, including ex_valid, all control signals, data and indices. Registers are cleared when RF_RESET=1.
- Latency: decode is combinational; its results appear on ID/EX outputs one clk edge later.
- Decode:
  - R 0110011: reg_write, alu_op=10.
  - I-ALU 0010011: reg_write, alu_src, alu_op=11.
  - LOAD 0000011: reg_write, mem_read, mem_to_reg, alu_src, alu_op=00.
  - STORE 0100011: mem_write, alu_src, alu_op=00.
  - BRANCH 1100011: branch, alu_op=01.
  - Any other opcode: all control signals 0 and illegal=1.
- Immediates: I, S and B formats, sign-extended to XLEN. Bit 0 of the B immediate is 0. R-type imm=0.
- Operand use: rs1 is used by every legal opcode. rs2 is used by R, STORE and BRANCH only.
- Register file write: occurs on the clk edge when wb_reg_write=1 and wb_rd≠0. Writes to x0 are ignored. Reads of x0 return 0.
- Register indices ≥ NREG:
  - Treated as illegal (illegal=1, controls 0).
  - Writes to them are ignored.
- Load-use stall: stall = id_valid & ex_mem_read & ex_rd≠0 & ((ex_rd==rs1 & rs1 used) | (ex_rd==rs2 & rs2 used)).
  - While stall=1 the next ID/EX is a bubble: ex_valid=0, all control signals and illegal 0, data fields don't-care (driven 0).
- Flush has priority over stall:
  - flush=1 forces a bubble and stall=0.
  - The IF/ID register is cleared by its owner.
- id_valid=0: bubble into ID/EX and stall=0.
- Normal advance: ex_valid=1 and all fields are captured.
- Reset mid-stall: outputs go to 0 immediately; stall follows its inputs, and id_valid is 0 after reset.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when wb_reg_write=1, wb_rd≠0 and wb_rd equals rs1 (or rs2), the corresponding operand captured into ID/EX is wb_data, not the stale register value (write-before-read in the same cycle).
- Undefined: operands always come from the array, so same-cycle readers see the old value. The hazard must then be covered by EX forwarding or software.

Test Plan:
- Reset low mid-run → all ID/EX outputs 0, ex_valid=0. After release, reading x5 returns 0 (RF_RESET=1).
- Write x3=0x0000_00AA via WB, then decode "add x1,x3,x3" → next edge gives rs1_data=rs2_data=0xAA, reg_write=1, alu_op=10, rd=1.
- EX holds "lw x4" (ex_mem_read=1, ex_rd=4), ID holds "add x6,x4,x2" → stall=1 and next ex_valid=0. Repeat with ex_rd=0 → stall=0.
- flush=1 asserted together with a load-use stall condition → stall=0, next ex_valid=0, reg_write=0.
- "sw x2,-8(x1)" → imm=0xFFFF_FFF8, mem_write=1, alu_src=1, reg_write=0. Branch offset -4 → imm=0xFFFF_FFFC.
- Same-cycle WB of x7=0x1234 while decoding "addi x8,x7,1":
  - ID_WB_BYPASS_EN defined → rs1_data=0x1234.
  - Undefined → rs1_data is the old x7. Also check the opcode 1111111 → illegal=1, all controls 0.
